// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// Build option: define RR_ARB_PRIO0_EN to make requester 0 urgent.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index width for NUM requesters; never narrower than one bit.
  function automatic int id_width(input int num);
    return (num <= 2) ? 1 : $clog2(num);
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin winner selection: first set index at or above ptr, else wrap.
// With RR_ARB_PRIO0_EN defined, a set req[0] always wins.
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter  int NUM  = 4,
  localparam int ID_W = id_width(NUM)
) (
  input  logic [NUM-1:0]  req,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] win_id,
  output logic [NUM-1:0]  win_oh
);

  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int i = 0; i < NUM; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found  = 1'b1;
        win_id = ID_W'(i);
      end
    end
    // Nothing at or above the pointer: wrap to the lowest set index.
    for (int i = 0; i < NUM; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        win_id = ID_W'(i);
      end
    end
`ifdef RR_ARB_PRIO0_EN
    if (req[0]) begin
      found  = 1'b1;
      win_id = '0;
    end
`endif
    win_oh = '0;
    if (found) begin
      win_oh[win_id] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered, non-preemptive round-robin arbiter with ack-based release and back-to-back grants.
// Build option: RR_ARB_PRIO0_EN (requester 0 urgent, its grants leave the pointer alone).
module rr_grant_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int NUM  = 4,
  localparam int ID_W = id_width(NUM)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NUM-1:0]  req_i,
  input  logic            ack_i,
  output logic [NUM-1:0]  gnt_o,
  output logic            gnt_vld_o,
  output logic [ID_W-1:0] gnt_id_o
);

  arb_state_e      state, state_d;
  logic [ID_W-1:0] ptr, ptr_d;
  logic [ID_W-1:0] adv_ptr;
  logic [ID_W-1:0] pick_ptr;
  logic [NUM-1:0]  gnt_d;
  logic [ID_W-1:0] gnt_id_d;
  logic            release_gnt;
  logic            found;
  logic [ID_W-1:0] win_id;
  logic [NUM-1:0]  win_oh;

  always_comb begin
    release_gnt = (state == GRANT) && (ack_i || !req_i[gnt_id_o]);
    adv_ptr     = (gnt_id_o == ID_W'(NUM - 1)) ? '0 : gnt_id_o + ID_W'(1);
`ifdef RR_ARB_PRIO0_EN
    if (gnt_id_o == '0) begin
      adv_ptr = ptr;
    end
`endif
    // A releasing winner re-arbitrates against the already-advanced pointer.
    pick_ptr = release_gnt ? adv_ptr : ptr;
  end

  rr_arb_pick #(
    .NUM (NUM)
  ) u_pick (
    .req    (req_i),
    .ptr    (pick_ptr),
    .found  (found),
    .win_id (win_id),
    .win_oh (win_oh)
  );

  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    gnt_d    = gnt_o;
    gnt_id_d = gnt_id_o;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_d    = win_oh;
          gnt_id_d = win_id;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (release_gnt) begin
          ptr_d = adv_ptr;
          if (found) begin
            gnt_d    = win_oh;
            gnt_id_d = win_id;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_o    <= '0;
      gnt_id_o <= '0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      gnt_o    <= gnt_d;
      gnt_id_o <= gnt_id_d;
    end
  end

  assign gnt_vld_o = |gnt_o;

endmodule
